// File: rtl/bp_pkg.sv
// Branch-predictor shared types and constants.
// Checkpoint layout {row, bank} and PHT 2-bit counter encodings.
package bp_pkg;

    localparam int PHT_INDEX_WIDTH = 8;
    localparam int PHT_ROW_WIDTH   = PHT_INDEX_WIDTH - 2;

    // 2-bit saturating counter states used by the PHT
    localparam logic [1:0] TAKE_S     = 2'b11;
    localparam logic [1:0] TAKE_W     = 2'b10;
    localparam logic [1:0] NOT_TAKE_W = 2'b01;
    localparam logic [1:0] NOT_TAKE_S = 2'b00;

    typedef struct packed {
        logic [PHT_ROW_WIDTH-1:0] row;
        logic [1:0]               bank;
    } ckpt_t;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Synchronous FIFO of predicted-branch checkpoints (ckpt_t).
// Ports: push/push_data, pop/head_data (show-ahead), flush, full, empty, count.
module ghr_ckpt_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  ckpt_t         push_data,
    input  logic          pop,
    input  logic          flush,
    output ckpt_t         head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    ckpt_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full && !flush;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ghr_index_gen.sv
// Gshare index generator: speculative/architectural GHRs, PHT read hash,
// checkpoint FIFO of predicted rows, and the registered PHT update stage.
// Ports: clock/reset, fetch_pc -> pht_index_r, br_pred_* push handshake,
// cmt_* commit/mispredict, pht_index_w/is_taken/pht_w_en update, ckpt_count.
module ghr_index_gen
    import bp_pkg::*;
#(
    parameter int PHT_INDEX_WIDTH = bp_pkg::PHT_INDEX_WIDTH,
    parameter int PHT_BANK        = 4,
    parameter int GHR_WIDTH       = PHT_INDEX_WIDTH - 2,
    parameter int CKPT_DEPTH      = 16,
    localparam int BANK_W = $clog2(PHT_BANK),
    localparam int CW     = $clog2(CKPT_DEPTH) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                fetch_pc,
    output logic [PHT_INDEX_WIDTH-3:0] pht_index_r,
    input  logic                       br_pred_valid,
    input  logic [31:0]                br_pred_pc,
    input  logic                       br_pred_taken,
    output logic                       br_pred_ready,
    input  logic                       cmt_valid,
    input  logic                       cmt_taken,
    input  logic                       cmt_mispredict,
    output logic [PHT_INDEX_WIDTH-1:0] pht_index_w,
    output logic                       is_taken,
    output logic                       pht_w_en,
    output logic [CW-1:0]              ckpt_count
);

    logic [GHR_WIDTH-1:0] spec_ghr;
    logic [GHR_WIDTH-1:0] arch_ghr;
    ckpt_t                push_ckpt;
    ckpt_t                head_ckpt;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc[31:PHT_INDEX_WIDTH+2], fetch_pc[3:0],
                              br_pred_pc[31:PHT_INDEX_WIDTH+2],
                              br_pred_pc[1:0]};

    assign pht_index_r = fetch_pc[PHT_INDEX_WIDTH+1:4] ^ spec_ghr;

    // A commit on an empty FIFO is ignored, including its mispredict flag.
    assign br_pred_ready = !full;
    assign pop           = cmt_valid && !empty;
    assign flush         = pop && cmt_mispredict;
    assign push          = br_pred_valid && !full && !flush;

    assign push_ckpt.row  = br_pred_pc[PHT_INDEX_WIDTH+1:4] ^ spec_ghr;
    assign push_ckpt.bank = br_pred_pc[BANK_W+1:2];

    ghr_ckpt_fifo #(
        .DEPTH(CKPT_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_ckpt),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_ckpt),
        .full      (full),
        .empty     (empty),
        .count     (ckpt_count)
    );

    // On mispredict the speculative history is rebuilt from the committed
    // history plus the resolved outcome; the wrong-path push is discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            if (pop) begin
                arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], cmt_taken};
            end
            if (flush) begin
                spec_ghr <= {arch_ghr[GHR_WIDTH-2:0], cmt_taken};
            end else if (push) begin
                spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], br_pred_taken};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pht_w_en    <= 1'b0;
            pht_index_w <= '0;
            is_taken    <= 1'b0;
        end else begin
            pht_w_en <= pop;
            if (pop) begin
                pht_index_w <= {head_ckpt.row, head_ckpt.bank};
                is_taken    <= cmt_taken;
            end
        end
    end

endmodule
